// File: rtl/npc_cmd_rx.sv
// npc_cmd_rx: SPI command receiver. Validates 32-bit frames, holds them in a
// shadow register and commits them to the modulator references on clk_int.
module npc_cmd_rx #(
    parameter int unsigned D_MAX       = 900,
    parameter int unsigned STATE_MAX   = 26,
    parameter int unsigned SAFE_STATE  = 0,
    parameter int unsigned WDG_PERIODS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic       clk_int,
    output logic [4:0] state_NPC,
    output logic [9:0] d_hb,
    output logic [9:0] d_boost,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       wdg_trip
);

    localparam int unsigned WDG_W       = $clog2(WDG_PERIODS + 1);
    localparam logic [WDG_W-1:0] WDG_LIM = WDG_W'(WDG_PERIODS);
    localparam logic [9:0] D_MAX_L      = 10'(D_MAX);
    localparam logic [4:0] STATE_MAX_L  = 5'(STATE_MAX);
    localparam logic [4:0] SAFE_L       = 5'(SAFE_STATE);
    localparam logic [5:0] CNT_SAT      = 6'd33;
    localparam logic [5:0] CNT_FRAME    = 6'd32;

    // Synchroniser chains: [0],[1] are the 2-FF sync, [2] is the edge reference.
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] mosi_sync_q, mosi_sync_d;
    logic [2:0] cs_sync_q,   cs_sync_d;
    logic [2:0] int_sync_q,  int_sync_d;

    logic sclk_rise_q, sclk_rise_d;
    logic mosi_bit_q,  mosi_bit_d;
    logic cs_rise_q,   cs_rise_d;
    logic cs_fall_q,   cs_fall_d;
    logic int_rise_q,  int_rise_d;

    logic [31:0] shift_q,   shift_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;

    logic [4:0] sh_state_q, sh_state_d;
    logic [9:0] sh_hb_q,    sh_hb_d;
    logic [9:0] sh_boost_q, sh_boost_d;
    logic       pending_q,  pending_d;

    logic [4:0]       state_q,     state_d;
    logic [9:0]       hb_q,        hb_d;
    logic [9:0]       boost_q,     boost_d;
    logic             frame_ok_q,  frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic             wdg_trip_q,  wdg_trip_d;
    logic [WDG_W-1:0] wdg_cnt_q,   wdg_cnt_d;

    logic [2:0] csum;
    logic [4:0] new_state;
    logic [9:0] new_hb;
    logic [9:0] new_boost;
    logic       accept;

    // Synchronisers, registered edge pulses and the SPI shift register.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        mosi_sync_d = {mosi_sync_q[1:0], mosi};
        cs_sync_d   = {cs_sync_q[1:0],   cs_n};
        int_sync_d  = {int_sync_q[1:0],  clk_int};
        sclk_rise_d = sclk_sync_q[1] & ~sclk_sync_q[2];
        mosi_bit_d  = mosi_sync_q[1];
        cs_rise_d   = cs_sync_q[1] & ~cs_sync_q[2];
        cs_fall_d   = ~cs_sync_q[1] & cs_sync_q[2];
        int_rise_d  = int_sync_q[1] & ~int_sync_q[2];
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        if (cs_fall_q) begin
            bit_cnt_d = '0;
        end else if (sclk_rise_q && !cs_sync_q[2]) begin
            shift_d = {shift_q[30:0], mosi_bit_q};
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
        end
    end

    // Frame decode: checksum, field extraction with duty clamping, validity.
    always_comb begin
        csum = '0;
        for (int i = 3; i <= 27; i++) begin
            csum = csum + 3'(shift_q[i]);
        end
        new_state = shift_q[27:23];
        new_hb    = (shift_q[22:13] > D_MAX_L) ? D_MAX_L : shift_q[22:13];
        new_boost = (shift_q[12:3]  > D_MAX_L) ? D_MAX_L : shift_q[12:3];
        accept    = cs_rise_q
                    && (bit_cnt_q == CNT_FRAME)
                    && (shift_q[31:28] == 4'hA)
                    && (shift_q[2:0] == csum)
                    && (new_state <= STATE_MAX_L);
    end

    // Shadow update, commit on clk_int and watchdog.
    always_comb begin
        sh_state_d  = sh_state_q;
        sh_hb_d     = sh_hb_q;
        sh_boost_d  = sh_boost_q;
        pending_d   = pending_q;
        state_d     = state_q;
        hb_d        = hb_q;
        boost_d     = boost_q;
        wdg_trip_d  = wdg_trip_q;
        wdg_cnt_d   = wdg_cnt_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        if (accept) begin
            sh_state_d = new_state;
            sh_hb_d    = new_hb;
            sh_boost_d = new_boost;
            pending_d  = 1'b1;
            frame_ok_d = 1'b1;
        end else if (cs_rise_q) begin
            frame_err_d = 1'b1;
        end

        if (int_rise_q) begin
            if (accept) begin
                // A frame landing on the commit edge goes straight to the outputs.
                state_d    = new_state;
                hb_d       = new_hb;
                boost_d    = new_boost;
                pending_d  = 1'b0;
                wdg_cnt_d  = '0;
                wdg_trip_d = 1'b0;
            end else if (pending_q) begin
                state_d    = sh_state_q;
                hb_d       = sh_hb_q;
                boost_d    = sh_boost_q;
                pending_d  = 1'b0;
                wdg_cnt_d  = '0;
                wdg_trip_d = 1'b0;
            end else begin
                if (wdg_cnt_q != WDG_LIM) begin
                    wdg_cnt_d = wdg_cnt_q + WDG_W'(1);
                end
                if (wdg_cnt_d == WDG_LIM) begin
                    state_d    = SAFE_L;
                    hb_d       = '0;
                    boost_d    = '0;
                    wdg_trip_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            int_sync_q  <= '0;
            sclk_rise_q <= 1'b0;
            mosi_bit_q  <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            int_rise_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            sh_state_q  <= SAFE_L;
            sh_hb_q     <= '0;
            sh_boost_q  <= '0;
            pending_q   <= 1'b0;
            state_q     <= SAFE_L;
            hb_q        <= '0;
            boost_q     <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wdg_trip_q  <= 1'b0;
            wdg_cnt_q   <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            int_sync_q  <= int_sync_d;
            sclk_rise_q <= sclk_rise_d;
            mosi_bit_q  <= mosi_bit_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            int_rise_q  <= int_rise_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_state_q  <= sh_state_d;
            sh_hb_q     <= sh_hb_d;
            sh_boost_q  <= sh_boost_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            hb_q        <= hb_d;
            boost_q     <= boost_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            wdg_trip_q  <= wdg_trip_d;
            wdg_cnt_q   <= wdg_cnt_d;
        end
    end

    assign state_NPC = state_q;
    assign d_hb      = hb_q;
    assign d_boost   = boost_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign wdg_trip  = wdg_trip_q;

endmodule

// File: tb/tb_npc_cmd_rx.sv
// Bench for npc_cmd_rx: directed table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_npc_cmd_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       clk_int = 1'b0;
    logic [4:0] state_NPC;
    logic [9:0] d_hb;
    logic [9:0] d_boost;
    logic       frame_ok;
    logic       frame_err;
    logic       wdg_trip;

    int n_cmp = 0;
    int n_err = 0;

    npc_cmd_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .clk_int(clk_int), .state_NPC(state_NPC), .d_hb(d_hb),
        .d_boost(d_boost), .frame_ok(frame_ok), .frame_err(frame_err),
        .wdg_trip(wdg_trip)
    );

    always #5 clk = ~clk;

    // Reference model: frame-level view of shadow, commit and watchdog.
    int m_sh_st, m_sh_hb, m_sh_bo;
    bit m_pend;
    int m_st, m_hb, m_bo, m_wdg;
    bit m_trip;

    task automatic model_reset();
        m_sh_st = 0; m_sh_hb = 0; m_sh_bo = 0; m_pend = 0;
        m_st = 0; m_hb = 0; m_bo = 0; m_wdg = 0; m_trip = 0;
    endtask

    function automatic int clampd(int v);
        return (v > 900) ? 900 : v;
    endfunction

    function automatic logic [31:0] mk_frame(logic [3:0] sync, int st, int hb, int bo);
        logic [24:0] p;
        p = {5'(st), 10'(hb), 10'(bo)};
        return {sync, p, 3'($countones(p) % 8)};
    endfunction

    function automatic bit model_valid(logic [31:0] d, int nbits);
        logic [24:0] p;
        p = d[27:3];
        return (nbits == 32) && (d[31:28] == 4'hA)
            && (int'(d[2:0]) == ($countones(p) % 8)) && (int'(d[27:23]) <= 26);
    endfunction

    task automatic model_accept(logic [31:0] d);
        m_sh_st = int'(d[27:23]);
        m_sh_hb = clampd(int'(d[22:13]));
        m_sh_bo = clampd(int'(d[12:3]));
        m_pend  = 1;
    endtask

    task automatic model_int();
        if (m_pend) begin
            m_st = m_sh_st; m_hb = m_sh_hb; m_bo = m_sh_bo;
            m_pend = 0; m_wdg = 0; m_trip = 0;
        end else begin
            if (m_wdg < 5) m_wdg++;
            if (m_wdg == 5) begin
                m_st = 0; m_hb = 0; m_bo = 0; m_trip = 1;
            end
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(string tag);
        check({tag, ".state"}, 32'(state_NPC), 32'(m_st));
        check({tag, ".d_hb"}, 32'(d_hb), 32'(m_hb));
        check({tag, ".d_boost"}, 32'(d_boost), 32'(m_bo));
        check({tag, ".wdg_trip"}, 32'(wdg_trip), 32'(m_trip));
    endtask

    task automatic start_cs();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic shift_bit(logic b);
        mosi = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    // Raise cs_n (optionally with clk_int on the same cycle) and check flag timing.
    task automatic finish_frame(logic exp_ok, logic with_int, logic [31:0] d);
        tick(4);
        cs_n = 1'b1;
        if (with_int) clk_int = 1'b1;
        tick(3);
        check("flag_early.ok", 32'(frame_ok), 32'd0);
        check("flag_early.err", 32'(frame_err), 32'd0);
        if (with_int) check_outs("coll_pre");
        tick(1);
        check("flag.ok", 32'(frame_ok), 32'(exp_ok));
        check("flag.err", 32'(frame_err), 32'(!exp_ok));
        if (exp_ok) model_accept(d);
        if (with_int) begin
            model_int();
            check_outs("coll");
        end
        tick(1);
        check("flag_after.ok", 32'(frame_ok), 32'd0);
        check("flag_after.err", 32'(frame_err), 32'd0);
        if (with_int) begin
            tick(5);
            clk_int = 1'b0;
            tick(4);
        end
        tick(2);
    endtask

    task automatic send_frame(logic [31:0] d, int nbits, logic exp_ok, logic with_int);
        start_cs();
        for (int i = 0; i < nbits; i++) begin
            if (i < 32) shift_bit(d[31-i]);
            else shift_bit(1'b0);
        end
        finish_frame(exp_ok, with_int, d);
    endtask

    task automatic pulse_int(string tag);
        clk_int = 1'b1;
        tick(3);
        check_outs({tag, "_pre"});
        tick(1);
        model_int();
        check_outs(tag);
        tick(6);
        clk_int = 1'b0;
        tick(4);
    endtask

    typedef struct {
        logic [31:0] data;
        int          nbits;
        logic        ok;
        logic [4:0]  st;
        logic [9:0]  hb;
        logic [9:0]  bo;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int          nb;
        int          r;
        bit          ok;

        tbl[0] = '{mk_frame(4'hA, 5, 500, 300),     32, 1'b1, 5'd5,  10'd500, 10'd300};
        tbl[1] = '{mk_frame(4'hA, 3, 1023, 10),     32, 1'b1, 5'd3,  10'd900, 10'd10};
        tbl[2] = '{mk_frame(4'hA, 27, 1, 1),        32, 1'b0, 5'd3,  10'd900, 10'd10};
        tbl[3] = '{mk_frame(4'hA, 7, 1, 2),         31, 1'b0, 5'd3,  10'd900, 10'd10};
        tbl[4] = '{mk_frame(4'hA, 26, 900, 1023),   32, 1'b1, 5'd26, 10'd900, 10'd900};
        tbl[5] = '{mk_frame(4'h5, 7, 1, 2),         32, 1'b0, 5'd26, 10'd900, 10'd900};
        tbl[6] = '{mk_frame(4'hA, 7, 1, 2) ^ 32'h1, 32, 1'b0, 5'd26, 10'd900, 10'd900};
        tbl[7] = '{mk_frame(4'hA, 7, 1, 2),         33, 1'b0, 5'd26, 10'd900, 10'd900};

        model_reset();
        tick(5);
        rst = 1'b0;
        tick(5);
        check_outs("reset");
        check("reset.frame_ok", 32'(frame_ok), 32'd0);
        check("reset.frame_err", 32'(frame_err), 32'd0);

        // Directed table: each frame followed by one commit edge.
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].nbits, tbl[i].ok, 1'b0);
            if (tbl[i].ok) check_outs("tbl_hold");
            pulse_int("tbl_commit");
            check("tbl.state", 32'(state_NPC), 32'(tbl[i].st));
            check("tbl.d_hb", 32'(d_hb), 32'(tbl[i].hb));
            check("tbl.d_boost", 32'(d_boost), 32'(tbl[i].bo));
        end

        // Watchdog trip after five empty periods, then recovery.
        send_frame(mk_frame(4'hA, 5, 500, 300), 32, 1'b1, 1'b0);
        pulse_int("wdg_commit");
        for (int i = 0; i < 5; i++) pulse_int("wdg_idle");
        check("wdg.trip", 32'(wdg_trip), 32'd1);
        check("wdg.state", 32'(state_NPC), 32'd0);
        send_frame(mk_frame(4'hA, 9, 100, 200), 32, 1'b1, 1'b0);
        pulse_int("wdg_recover");
        check("wdg.cleared", 32'(wdg_trip), 32'd0);
        check("wdg.new_hb", 32'(d_hb), 32'd100);

        // Collision: frame accepted on the commit edge, pending must end at 0.
        send_frame(mk_frame(4'hA, 12, 34, 56), 32, 1'b1, 1'b1);
        check("coll.state", 32'(state_NPC), 32'd12);
        for (int i = 0; i < 5; i++) pulse_int("coll_idle");
        check("coll.trip_after5", 32'(wdg_trip), 32'd1);

        // Newest wins within one period.
        send_frame(mk_frame(4'hA, 1, 2, 3), 32, 1'b1, 1'b0);
        send_frame(mk_frame(4'hA, 4, 5, 6), 32, 1'b1, 1'b0);
        pulse_int("newest");
        check("newest.state", 32'(state_NPC), 32'd4);
        check("newest.d_boost", 32'(d_boost), 32'd6);

        // Reset in the middle of a frame; the tail is counted from zero.
        d = mk_frame(4'hA, 20, 700, 800);
        start_cs();
        for (int i = 0; i < 16; i++) shift_bit(d[31-i]);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(1);
        check_outs("midrst");
        tick(4);
        for (int i = 16; i < 32; i++) shift_bit(d[31-i]);
        finish_frame(1'b0, 1'b0, d);
        pulse_int("midrst_commit");

        // Randomized frames against the reference model.
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) begin
                nb = 32;
                d = mk_frame(4'hA, int'($urandom_range(0, 26)),
                             int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
                case ($urandom_range(0, 5))
                    3: d[31:28] = 4'($urandom_range(0, 15));
                    4: d = d ^ (32'h1 << $urandom_range(0, 2));
                    5: if ($urandom_range(0, 1) == 1) nb = 31 + int'($urandom_range(0, 1)) * 2;
                       else d = mk_frame(4'hA, int'($urandom_range(27, 31)), 5, 5);
                    default: ;
                endcase
                ok = model_valid(d, nb);
                send_frame(d, nb, ok, (r == 7));
                if (r != 7 && $urandom_range(0, 1) == 1) pulse_int("rnd_commit");
            end else begin
                pulse_int("rnd_idle");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/npc_cmd_rx.md
# npc_cmd_rx

Serial command receiver that sits directly upstream of the converter modulator (NPC dead-time stage, half-bridge and boost PWM stages). It receives 32-bit command frames from the control MCU over a mode-0 SPI link, validates them, holds them in a shadow register, and commits them to `state_NPC`, `d_hb` and `d_boost` only on the rising edge of the 20 µs control interrupt `clk_int`. Switching references therefore never change mid-period. A watchdog forces a safe output set if the MCU stops sending frames.

## Interface
- `D_MAX`, 900: upper clamp for both duty outputs.
- `STATE_MAX`, 26: highest legal NPC state code; larger codes reject the frame.
- `SAFE_STATE`, 0: NPC state forced on reset and on watchdog trip.
- `WDG_PERIODS`, 5: consecutive `clk_int` periods without a new frame before the watchdog trips.
- `clk`  in  1  100 MHz system clock, same clock as the modulator.
- `rst`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from the MCU, asynchronous, at most clk/8.
- `mosi`  in  1  SPI data, MSB first, sampled on `sclk` rising.
- `cs_n`  in  1  SPI frame select, active low.
- `clk_int`  in  1  20 µs interrupt from the modulator, treated as asynchronous.
- `state_NPC`  out  5  committed NPC state.
- `d_hb`  out  10  committed half-bridge duty.
- `d_boost`  out  10  committed boost duty.
- `frame_ok`  out  1  one-cycle pulse when a frame is accepted into the shadow register.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.
- `wdg_trip`  out  1  sticky watchdog flag.

## Operation
- **Synchronisation:** `sclk`, `mosi`, `cs_n` and `clk_int` each pass through 2-FF synchronisers. Edges are detected against a third registered copy.
- **Shifting:** while synced `cs_n` is low, each synced `sclk` rising edge shifts `mosi` into a 32-bit shift register and increments a 6-bit bit counter, saturating at 33. A `cs_n` falling edge clears the counter.
- **Frame format:**
  - [31:28] sync nibble `4'hA`
  - [27:23] state
  - [22:13] `d_hb`
  - [12:3] `d_boost`
  - [2:0] checksum = popcount([27:3]) mod 8
- **Validation (on the synced `cs_n` rising edge):** the frame is accepted only if all of the following hold:
  - bit count is exactly 32
  - sync nibble is `4'hA`
  - checksum matches
  - state ≤ `STATE_MAX`
  
  Duty fields above `D_MAX` are clamped to `D_MAX`; this does not cause an error.
- **Accepted frame:** written to the shadow register, `pending` set, `frame_ok` pulsed.
- **Rejected frame:** shadow register and `pending` unchanged, `frame_err` pulsed.
- **Commit (on the synced `clk_int` rising edge):**
  - `pending`=1: copy shadow to outputs, clear `pending`, clear the watchdog counter, clear `wdg_trip`.
  - `pending`=0: increment the watchdog counter, saturating. When it reaches `WDG_PERIODS`, set the outputs to `SAFE_STATE`/0/0 and set `wdg_trip`.
- **Simultaneous validation and commit in the same cycle:** the newly accepted frame is committed directly, and `pending` ends at 0.
- **Two frames in one period:** the later accepted frame overwrites the shadow register (newest wins).

## Timing
- **Reset values:**
  - `state_NPC`=`SAFE_STATE`, `d_hb`=0, `d_boost`=0
  - `frame_ok`=0, `frame_err`=0, `wdg_trip`=0
  - `pending`=0, watchdog counter=0, shift register and bit counter=0
- **Reset mid-frame:** the partial frame is discarded. If `cs_n` is still low when reset releases, the remaining bits are counted from 0, and that frame is rejected at `cs_n` rise.
- **Outputs after `clk_int` rise:** update on the 4th `clk` rising edge after `clk_int` rises at the pin (2 sync + 1 edge register + 1 output register).
- **Frame flags after `cs_n` rise:** `frame_ok`/`frame_err` assert on the 4th `clk` edge after `cs_n` rises, for exactly one cycle.
- **Steady outputs:** outputs are registered and change only on commit, watchdog trip or reset.
- **`sclk` edges while `cs_n` is high:** ignored.
- **Over-long frames:** more than 32 bits saturates the counter and the frame is rejected.

## Test plan
- **Good frame:** state=5, `d_hb`=500, `d_boost`=300, correct checksum → `frame_ok` pulse; outputs stay 0/0/0 until the next `clk_int` rise, then become 5/500/300 four cycles later.
- **Clamp and reject:** `d_hb`=1023 → committed `d_hb`=900. Separately, state=27 → `frame_err` pulse and outputs unchanged.
- **Bad framing:** a 31-bit frame, a sync nibble of `4'h5`, and a flipped checksum bit → each produces `frame_err`; the previously committed values are held.
- **Watchdog:** commit 5/500/300, then send no frames for 5 `clk_int` periods → after the 5th rise, outputs = 0/0/0 and `wdg_trip`=1. A following valid frame plus `clk_int` rise → new values committed and `wdg_trip`=0.
- **Collision and newest-wins:** a frame accepted in the same cycle as the synced `clk_int` edge → committed immediately, `pending`=0. Two frames within one period → only the second is committed.
- **Reset mid-operation:** assert `rst` after 16 bits of a frame → all outputs return to reset values; the frame completing after reset is rejected.
